// File: rtl/ps2_game_menu_if.sv
// ps2_game_menu_if: keyboard byte stream in, menu/game status out
interface ps2_game_menu_if;
  logic [7:0] key_data;
  logic       key_valid;
  logic [2:0] state_code;
  logic [3:0] speed;
  logic [3:0] difficulty;
  logic [7:0] time_left;
  logic       game_active;
  logic       game_over_pulse;
  modport master (output key_data, key_valid,
                  input state_code, speed, difficulty, time_left, game_active, game_over_pulse);
  modport slave  (input key_data, key_valid,
                  output state_code, speed, difficulty, time_left, game_active, game_over_pulse);
endinterface

// File: rtl/ps2_game_menu_ctrl.sv
// ps2_game_menu_ctrl: PS/2 driven speed/difficulty menu with a ticking game timer
module ps2_game_menu_ctrl #(
  parameter int NUM_LEVELS   = 3,
  parameter int GAME_SECONDS = 60,
  parameter int TICK_CYCLES  = 50000000
) (
  input logic             CLOCK_50,
  input logic             resetn,
  ps2_game_menu_if.slave  bus
);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [3:0]    MAX_D    = 4'(NUM_LEVELS);
  localparam logic [7:0]    SECS     = 8'(GAME_SECONDS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
  localparam logic [2:0] SEL_SPEED = 3'd0, SPEED_REL = 3'd1, SEL_DIFF = 3'd2, DIFF_REL = 3'd3,
                         READY = 3'd4, PLAYING = 3'd5, GAME_OVER = 3'd6;
  logic [2:0]    state_q, state_d;
  logic [3:0]    speed_q, speed_d, diff_q, diff_d;
  logic [7:0]    time_q, time_d, code_q, code_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          brk_q, brk_d, ext_q, ext_d, gop_q, gop_d;
  logic          is_f0, is_e0, ev, mk, bk, dv, esc, space, wrap;
  logic [3:0]    d;
  function automatic logic [3:0] digit_of(input logic [7:0] b);
    case (b)
      8'h16: digit_of = 4'd1;
      8'h1E: digit_of = 4'd2;
      8'h26: digit_of = 4'd3;
      8'h25: digit_of = 4'd4;
      8'h2E: digit_of = 4'd5;
      8'h36: digit_of = 4'd6;
      8'h3D: digit_of = 4'd7;
      8'h3E: digit_of = 4'd8;
      8'h46: digit_of = 4'd9;
      default: digit_of = 4'd0;
    endcase
  endfunction
  // Prefix tracking: F0/E0 arm flags, any other byte is an event that consumes them
  always_comb begin
    is_f0 = bus.key_valid && bus.key_data == 8'hF0;
    is_e0 = bus.key_valid && bus.key_data == 8'hE0;
    ev    = bus.key_valid && !is_f0 && !is_e0;
    brk_d = ev ? 1'b0 : (brk_q | is_f0);
    ext_d = ev ? 1'b0 : (ext_q | is_e0);
    mk    = ev && !brk_q && !ext_q;
    bk    = ev && brk_q && !ext_q;
    d     = digit_of(bus.key_data);
    dv    = d != 4'd0 && d <= MAX_D;
    esc   = mk && bus.key_data == 8'h76;
    space = mk && bus.key_data == 8'h29;
    wrap  = tick_q == TICK_MAX;
  end
  // Menu/game FSM; Esc overrides everything, timer runs every cycle while playing
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    diff_d  = diff_q;
    time_d  = time_q;
    tick_d  = tick_q;
    code_d  = code_q;
    if (esc) begin
      state_d = SEL_SPEED;
      speed_d = '0;
      diff_d  = '0;
      time_d  = '0;
      tick_d  = '0;
      code_d  = '0;
    end else begin
      case (state_q)
        SEL_SPEED: if (mk && dv) begin
          speed_d = d;
          code_d  = bus.key_data;
          state_d = SPEED_REL;
        end
        SPEED_REL: if (bk && bus.key_data == code_q) state_d = SEL_DIFF;
        SEL_DIFF: if (mk && dv) begin
          diff_d  = d;
          code_d  = bus.key_data;
          state_d = DIFF_REL;
        end
        DIFF_REL: if (bk && bus.key_data == code_q) state_d = READY;
        READY: if (space) begin
          state_d = PLAYING;
          time_d  = SECS;
          tick_d  = '0;
        end
        PLAYING: begin
          tick_d  = wrap ? '0 : tick_q + 1'b1;
          time_d  = wrap ? time_q - 8'd1 : time_q;
          state_d = (wrap && time_q == 8'd1) ? GAME_OVER : PLAYING;
        end
        GAME_OVER: if (space) begin
          state_d = SEL_SPEED;
          speed_d = '0;
          diff_d  = '0;
        end
        default: state_d = SEL_SPEED;
      endcase
    end
    gop_d = state_d == GAME_OVER && state_q != GAME_OVER;
  end
  // State registers with asynchronous clear
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEL_SPEED;
      speed_q <= '0;
      diff_q  <= '0;
      time_q  <= '0;
      tick_q  <= '0;
      code_q  <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      gop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      diff_q  <= diff_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
      code_q  <= code_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      gop_q   <= gop_d;
    end
  end
  assign bus.state_code      = state_q;
  assign bus.speed           = speed_q;
  assign bus.difficulty      = diff_q;
  assign bus.time_left       = time_q;
  assign bus.game_active     = state_q == PLAYING;
  assign bus.game_over_pulse = gop_q;
endmodule
